// File: rtl/rv32i_types.sv
// Shared types for the branch predictor: 2-bit counter states and update rule.
package rv32i_types;

  localparam int unsigned PC_W   = 32;
  localparam int unsigned STAT_W = 32;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } bht_state_t;

  // Saturating step: taken moves toward ST, not-taken toward SNT.
  function automatic bht_state_t bht_next(input bht_state_t s, input logic taken);
    if (taken) begin
      return (s == ST) ? ST : bht_state_t'(2'(s) + 2'd1);
    end
    return (s == SNT) ? SNT : bht_state_t'(2'(s) - 2'd1);
  endfunction

endpackage

// File: rtl/bht_array.sv
// Branch history table storage: one combinational read port, one
// read-modify-write update port, asynchronous reset of every entry to WNT.
module bht_array
  import rv32i_types::*;
#(
  parameter int unsigned IDX_BITS = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [IDX_BITS-1:0] rd_idx,
  output bht_state_t          rd_state_c,
  input  logic                wr_en,
  input  logic [IDX_BITS-1:0] wr_idx,
  input  logic                wr_taken
);

  localparam int unsigned ENTRIES = 1 << IDX_BITS;

  bht_state_t mem [ENTRIES];

  // Counter storage; the update reads the old entry and writes its saturated step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        mem[i] <= WNT;
      end
    end else if (wr_en) begin
      mem[wr_idx] <= bht_next(mem[wr_idx], wr_taken);
    end
  end

  // Lookup sees the pre-update value; no write-to-read bypass.
  assign rd_state_c = mem[rd_idx];

endmodule

// File: rtl/branch_predictor.sv
// Bimodal branch predictor: 2-bit counter table, mispredict pulse and statistics.
module branch_predictor
  import rv32i_types::*;
#(
  parameter int unsigned IDX_BITS = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [PC_W-1:0]   fetch_pc,
  output logic              pred_taken,
  input  logic              upd_valid,
  input  logic [PC_W-1:0]   upd_pc,
  input  logic              upd_taken,
  input  logic              upd_pred,
  output logic              mispredict,
  output logic [STAT_W-1:0] stat_branches,
  output logic [STAT_W-1:0] stat_mispredicts
);

  logic [IDX_BITS-1:0] fetch_idx;
  logic [IDX_BITS-1:0] upd_idx;
  bht_state_t          fetch_state;
  logic                unused_pc_bits;

  // Word-aligned PC bits select the table entry.
  assign fetch_idx = fetch_pc[IDX_BITS+1:2];
  assign upd_idx   = upd_pc[IDX_BITS+1:2];

  // PC bits outside the index field do not affect prediction.
  assign unused_pc_bits = ^{fetch_pc[PC_W-1:IDX_BITS+2], fetch_pc[1:0],
                            upd_pc[PC_W-1:IDX_BITS+2], upd_pc[1:0]};

  bht_array #(.IDX_BITS(IDX_BITS)) u_bht (
    .clk        (clk),
    .rst_n      (rst_n),
    .rd_idx     (fetch_idx),
    .rd_state_c (fetch_state),
    .wr_en      (upd_valid),
    .wr_idx     (upd_idx),
    .wr_taken   (upd_taken)
  );

  // Upper counter bit is the predicted direction.
  assign pred_taken = fetch_state[1];

  // Mispredict pulse and free-running (wrapping) statistics.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mispredict       <= 1'b0;
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else begin
      mispredict <= upd_valid & (upd_taken ^ upd_pred);
      if (upd_valid) begin
        stat_branches <= stat_branches + STAT_W'(1);
        if (upd_taken != upd_pred) begin
          stat_mispredicts <= stat_mispredicts + STAT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor with a reference model
// and a queue of expected mispredict pulses.
module tb_branch_predictor;

  logic        clk;
  logic        rst_n;
  logic [31:0] fetch_pc;
  logic        pred_taken;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic        upd_pred;
  logic        mispredict;
  logic [31:0] stat_branches;
  logic [31:0] stat_mispredicts;

  int tests_run;
  int tests_failed;

  // Reference model
  logic [1:0]  m_tab [32];
  logic [31:0] m_br;
  logic [31:0] m_mis;
  logic        exp_q[$];

  branch_predictor #(.IDX_BITS(5)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .fetch_pc         (fetch_pc),
    .pred_taken       (pred_taken),
    .upd_valid        (upd_valid),
    .upd_pc           (upd_pc),
    .upd_taken        (upd_taken),
    .upd_pred         (upd_pred),
    .mispredict       (mispredict),
    .stat_branches    (stat_branches),
    .stat_mispredicts (stat_mispredicts)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned midx(input logic [31:0] pc);
    return int'((pc >> 2) & 32'd31);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_tab[i] = 2'b01;
    m_br  = 32'd0;
    m_mis = 32'd0;
    exp_q.delete();
  endtask

  // One clock: drive at negedge, check same-cycle prediction, then check
  // registered outputs at the following negedge.
  task automatic cycle(input logic v, input logic [31:0] fpc, input logic [31:0] upc,
                       input logic t, input logic p, input string tag);
    logic [31:0] i;
    logic        e;
    @(negedge clk);
    fetch_pc  = fpc;
    upd_valid = v;
    upd_pc    = upc;
    upd_taken = t;
    upd_pred  = p;
    #1;
    check({tag, "_pred_pre"}, {31'd0, pred_taken}, {31'd0, m_tab[midx(fpc)][1]});
    exp_q.push_back(v & (t ^ p));
    if (v) begin
      i = midx(upc);
      if (t) m_tab[i] = (m_tab[i] == 2'b11) ? 2'b11 : m_tab[i] + 2'b01;
      else   m_tab[i] = (m_tab[i] == 2'b00) ? 2'b00 : m_tab[i] - 2'b01;
      m_br = m_br + 32'd1;
      if (t != p) m_mis = m_mis + 32'd1;
    end
    @(negedge clk);
    upd_valid = 1'b0;
    e = exp_q.pop_front();
    check({tag, "_mispredict"}, {31'd0, mispredict}, {31'd0, e});
    check({tag, "_branches"}, stat_branches, m_br);
    check({tag, "_mispredicts"}, stat_mispredicts, m_mis);
    check({tag, "_pred_post"}, {31'd0, pred_taken}, {31'd0, m_tab[midx(fpc)][1]});
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n     = 1'b0;
    fetch_pc  = 32'h0000_0040;
    upd_valid = 1'b1;
    upd_pc    = 32'h0000_0040;
    upd_taken = 1'b1;
    upd_pred  = 1'b0;
    model_reset();

    // Reset: an update held during reset must be discarded
    #2;
    check("rst_pred", {31'd0, pred_taken}, 32'd0);
    check("rst_misp", {31'd0, mispredict}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_hold_branches", stat_branches, 32'd0);
    check("rst_hold_misp", {31'd0, mispredict}, 32'd0);
    @(negedge clk);
    upd_valid = 1'b0;
    rst_n     = 1'b1;
    #1;
    check("rst_rel_pred", {31'd0, pred_taken}, 32'd0);
    check("rst_rel_branches", stat_branches, 32'd0);
    check("rst_rel_mispredicts", stat_mispredicts, 32'd0);

    // Training: WNT -> WT -> ST
    cycle(1'b1, 32'h100, 32'h100, 1'b1, 1'b0, "train1");
    cycle(1'b1, 32'h100, 32'h100, 1'b1, 1'b0, "train2");
    check("train_pred", {31'd0, pred_taken}, 32'd1);
    check("train_mispredicts", stat_mispredicts, 32'd2);

    // Aliasing: 0x180 shares the entry, 0x104 does not
    cycle(1'b0, 32'h180, 32'h0, 1'b0, 1'b0, "alias180");
    check("alias180_taken", {31'd0, pred_taken}, 32'd1);
    cycle(1'b0, 32'h104, 32'h0, 1'b0, 1'b0, "alias104");
    check("alias104_nt", {31'd0, pred_taken}, 32'd0);

    // Idle cycle with upd_taken high must not change the table
    cycle(1'b0, 32'h100, 32'h100, 1'b1, 1'b1, "idle");

    // Saturation: more taken updates stay ST, one not-taken -> WT
    for (int k = 0; k < 5; k++) cycle(1'b1, 32'h100, 32'h100, 1'b1, 1'b1, "sat_t");
    cycle(1'b1, 32'h100, 32'h100, 1'b0, 1'b1, "sat_nt");
    check("sat_entry_wt", {30'd0, m_tab[0]}, 32'd2);
    check("sat_pred", {31'd0, pred_taken}, 32'd1);
    check("sat_misp_pulse", {31'd0, mispredict}, 32'd1);

    // Mid-run reset between edges: outputs clear without a clock
    rst_n = 1'b0;
    #1;
    model_reset();
    check("midrst_pred", {31'd0, pred_taken}, 32'd0);
    check("midrst_misp", {31'd0, mispredict}, 32'd0);
    check("midrst_branches", stat_branches, 32'd0);
    check("midrst_mispredicts", stat_mispredicts, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Learned history is gone: 0x100 back at WNT
    cycle(1'b0, 32'h100, 32'h0, 1'b0, 1'b0, "post_rst");

    // Same-index collision: pre-update value now, new value next cycle
    cycle(1'b1, 32'h200, 32'h200, 1'b1, 1'b0, "collide");
    cycle(1'b1, 32'h200, 32'h200, 1'b1, 1'b1, "collide2");
    check("collide_pred", {31'd0, pred_taken}, 32'd1);

    // Not-taken to a separate entry saturates at SNT
    cycle(1'b1, 32'h104, 32'h104, 1'b0, 1'b0, "snt1");
    cycle(1'b1, 32'h104, 32'h104, 1'b0, 1'b1, "snt2");
    check("snt_entry", {30'd0, m_tab[1]}, 32'd0);

    // Wrap: preload counter to all ones, one update -> zero
    @(negedge clk);
    dut.stat_branches = 32'hFFFF_FFFF;
    m_br = 32'hFFFF_FFFF;
    cycle(1'b1, 32'h0, 32'h8, 1'b1, 1'b1, "wrap");
    check("wrap_zero", stat_branches, 32'd0);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Global time bound
  initial begin
    #50000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL have parameter IDX_BITS, default 5, meaning log2 of the branch-history-table entry count (32 entries).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, the reset; asynchronous and active-low.
REQ-004 SHALL have port fetch_pc, input, 32, the PC of the instruction being fetched.
REQ-005 SHALL have port pred_taken, output, 1, the predicted direction for fetch_pc.
REQ-006 SHALL have port upd_valid, input, 1, high for one cycle when a branch resolves in execute.
REQ-007 SHALL have port upd_pc, input, 32, the PC of the resolving branch.
REQ-008 SHALL have port upd_taken, input, 1, the resolved outcome, driven by the branch comparator flag.
REQ-009 SHALL have port upd_pred, input, 1, the prediction that was carried down the pipe with the branch.
REQ-010 SHALL have port mispredict, output, 1, a registered pulse: the resolved branch was mispredicted.
REQ-011 SHALL have port stat_branches, output, 32, the count of resolved branches.
REQ-012 SHALL have port stat_mispredicts, output, 32, the count of mispredicted branches.

Function
REQ-013 SHALL index the table with pc[IDX_BITS+1:2] for both lookup and update.
REQ-014 SHALL hold one 2-bit saturating counter per entry, with states SNT=00, WNT=01, WT=10, ST=11.
REQ-015 SHALL drive pred_taken combinationally (zero latency) as bit 1 of the counter at the fetch index.
REQ-016 SHALL apply the update on an edge with upd_valid=1: upd_taken=1 increments, saturating at ST; upd_taken=0 decrements, saturating at SNT.
REQ-017 SHALL leave every entry unchanged on an edge with upd_valid=0.
REQ-018 SHALL give no bypass when lookup and update hit the same index in the same cycle: pred_taken shows the pre-update value, and the new value is visible the next cycle.
REQ-019 SHALL register mispredict as upd_valid & (upd_taken ^ upd_pred), so it is high exactly one cycle after the update cycle and low otherwise.
REQ-020 SHALL increment stat_branches on each upd_valid edge.
REQ-021 SHALL increment stat_mispredicts on each upd_valid edge with upd_taken != upd_pred.
REQ-022 SHALL let both statistics counters wrap modulo 2^32 (0xFFFFFFFF+1 -> 0) with no flag.
REQ-023 SHALL treat an X or unknown upd_taken as don't-care; it is not checked.

Reset
REQ-024 SHALL, while rst_n=0, force every table entry to WNT (01) immediately, without waiting for a clock edge.
REQ-025 SHALL, while rst_n=0, hold pred_taken=0, mispredict=0, stat_branches=0 and stat_mispredicts=0.
REQ-026 SHALL discard an update presented in the cycle rst_n deasserts only if rst_n is still low at that edge; otherwise the update is applied normally.
REQ-027 SHALL, on reset asserted mid-operation, lose all learned history; the pipeline flushes separately.

Structure
REQ-028 SHALL define the bht_state_t enum (SNT/WNT/WT/ST) in rv32i_types.
REQ-029 SHALL place the increment/decrement function on bht_state_t in rv32i_types.
REQ-030 SHALL split out one sub-module, bht_array, holding the counter storage with one combinational read port, one write port, and async reset to WNT.
REQ-031 SHALL keep the statistics counters and the mispredict register in branch_predictor.

Verification
REQ-032 SHALL cover reset: drive rst_n=0, release, fetch_pc=0x00000040 -> pred_taken=0, both statistics counters = 0.
REQ-033 SHALL cover training: 2 updates with upd_pc=0x100, upd_taken=1, upd_pred=0 -> entry goes WNT->WT->ST; pred_taken=1 at fetch_pc=0x100; stat_mispredicts=2; mispredict high the cycle after each update.
REQ-034 SHALL cover saturation: 5 taken updates to 0x100 then 1 not-taken -> entry = WT, pred_taken remains 1.
REQ-035 SHALL cover aliasing: update 0x100 taken twice -> fetch_pc=0x180 (same index with IDX_BITS=5) predicts taken, fetch_pc=0x104 predicts not-taken.
REQ-036 SHALL cover same-index collision: fetch_pc=upd_pc=0x200, entry WNT, upd_taken=1 -> pred_taken=0 this cycle, 1 next cycle.
REQ-037 SHALL cover wrap and mid-run reset: preload stat_branches=0xFFFFFFFF, one update -> 0x00000000; asserting rst_n=0 between clock edges -> outputs zero before the next edge.
